oled_refresh_scheduler: RTL and testbench

// Sits between the digit sources and data_streamer. Arbitrates two digit sources:

---
 rtl/oled_refresh_scheduler.sv | 152 +++++++++++++++
 tb/tb_oled_refresh_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/oled_refresh_scheduler.sv
// oled_refresh_scheduler
// Arbitrates two digit sources (meas, msg) in front of the OLED data streamer.
// Each source has a one-deep "latest wins" slot. Frame starts are spaced by at
// least MIN_PERIOD_CYCLES. One refresh strobe is issued per frame. A watchdog
// aborts a frame if the streamer handshake stalls.
//
// Ports:
//   clk_in, reset_n_in        clock, async active-low reset
//   meas_digits_in/valid_in   measurement digits + 1-cycle load strobe
//   msg_digits_in/valid_in    message digits + 1-cycle load strobe
//   msg_hold_in               level: meas is held back while high
//   digits_out                frame digits, updated only on grant
//   refresh_stb_out           1-cycle frame start pulse to the streamer
//   streamer_ready_in         streamer idle/ready
//   busy_out                  frame in flight
//   timeout_out               sticky watchdog flag
//   overrun_cnt_out           saturating count of overwritten pending meas
//
// Build option: SCHED_BLANK_LEADING_ZEROS_EN replaces leading zero digits of a
// meas frame with 4'hF (blank code); the LSD is always shown.
module oled_refresh_scheduler #(
  parameter int DIGITS_NUM        = 6,
  parameter int MIN_PERIOD_CYCLES = 120000,
  parameter int TIMEOUT_CYCLES    = 1000000
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic [4*DIGITS_NUM-1:0] meas_digits_in,
  input  logic                    meas_valid_in,
  input  logic [4*DIGITS_NUM-1:0] msg_digits_in,
  input  logic                    msg_valid_in,
  input  logic                    msg_hold_in,
  output logic [4*DIGITS_NUM-1:0] digits_out,
  output logic                    refresh_stb_out,
  input  logic                    streamer_ready_in,
  output logic                    busy_out,
  output logic                    timeout_out,
  output logic [7:0]              overrun_cnt_out
);

  localparam int DW = 4 * DIGITS_NUM;
  localparam int PW = $clog2(MIN_PERIOD_CYCLES);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PLOAD = PW'(MIN_PERIOD_CYCLES - 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] meas_data, msg_data, win_data;
  logic          meas_pend, msg_pend;
  logic [PW-1:0] period_q;
  logic [WW-1:0] wd_q;
  logic          grant, grant_msg, grant_meas, wd_fire;

`ifdef SCHED_BLANK_LEADING_ZEROS_EN
  // Walk from the MSD down; stop at the first non-zero digit. Digit 0 excluded.
  function automatic logic [DW-1:0] blank_lz(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic          lead;
    r    = d;
    lead = 1'b1;
    for (int i = DIGITS_NUM - 1; i >= 1; i--) begin
      if (lead && d[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
      else                             lead = 1'b0;
    end
    return r;
  endfunction
`endif

  always_comb begin
    grant      = (state_q == IDLE) && streamer_ready_in && (period_q == '0) &&
                 (msg_pend || (meas_pend && !msg_hold_in));
    grant_msg  = grant && msg_pend;
    grant_meas = grant && !msg_pend;
`ifdef SCHED_BLANK_LEADING_ZEROS_EN
    win_data   = grant_msg ? msg_data : blank_lz(meas_data);
`else
    win_data   = grant_msg ? msg_data : meas_data;
`endif
    // Abort only if the awaited edge has not arrived in the last allowed cycle.
    wd_fire    = (wd_q == WLAST) &&
                 (((state_q == WAIT_BUSY) && streamer_ready_in) ||
                  ((state_q == WAIT_DONE) && !streamer_ready_in));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (wd_fire) state_d = IDLE;
                 else if (!streamer_ready_in) state_d = WAIT_DONE;
      WAIT_DONE: if (wd_fire) state_d = IDLE;
                 else if (streamer_ready_in) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      meas_data       <= '0;
      msg_data        <= '0;
      meas_pend       <= 1'b0;
      msg_pend        <= 1'b0;
      period_q        <= '0;
      wd_q            <= '0;
      digits_out      <= '0;
      refresh_stb_out <= 1'b0;
      busy_out        <= 1'b0;
      timeout_out     <= 1'b0;
      overrun_cnt_out <= '0;
    end else begin
      // A valid in the grant cycle re-arms the slot for the next frame.
      if (meas_valid_in) begin
        meas_data <= meas_digits_in;
        meas_pend <= 1'b1;
      end else if (grant_meas) begin
        meas_pend <= 1'b0;
      end
      if (msg_valid_in) begin
        msg_data <= msg_digits_in;
        msg_pend <= 1'b1;
      end else if (grant_msg) begin
        msg_pend <= 1'b0;
      end

      if (meas_valid_in && meas_pend && !grant_meas && overrun_cnt_out != 8'hFF)
        overrun_cnt_out <= overrun_cnt_out + 8'd1;

      // Counter reads MIN-1 during the strobe cycle, so the next strobe can
      // land exactly MIN_PERIOD_CYCLES after this one.
      if (grant)                 period_q <= PLOAD;
      else if (period_q != '0)   period_q <= period_q - 1'b1;

      if (state_q == ISSUE)                                      wd_q <= '0;
      else if (state_q == WAIT_BUSY || state_q == WAIT_DONE)     wd_q <= wd_q + 1'b1;

      if (grant)   digits_out  <= win_data;
      if (wd_fire) timeout_out <= 1'b1;

      refresh_stb_out <= grant;
      busy_out        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_oled_refresh_scheduler.sv
// Self-checking bench for oled_refresh_scheduler (DIGITS_NUM=6, MIN=16,
// TIMEOUT=64) with a simple streamer model that drops ready for FRAME cycles
// after each strobe, or never drops it when 'stuck' is set.
module tb_oled_refresh_scheduler;
  localparam int DN = 6, MP = 16, TO = 64, FRAME = 8;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic [23:0] meas_digits_in, msg_digits_in, digits_out;
  logic        meas_valid_in, msg_valid_in, msg_hold_in;
  logic        refresh_stb_out, busy_out, timeout_out;
  logic        streamer_ready_in = 1'b1;
  logic [7:0]  overrun_cnt_out;
  logic        stuck;
  int          scnt = 0;
  int          vec_cnt = 0, err_cnt = 0;

`ifdef SCHED_BLANK_LEADING_ZEROS_EN
  localparam logic [23:0] E_001234 = 24'hFF1234, E_000000 = 24'hFFFFF0,
                          E_000005 = 24'hFFFFF5, E_0A0B00 = 24'hFA0B00,
                          E_000987 = 24'hFFF987, E_000333 = 24'hFFF333,
                          E_000042 = 24'hFFFF42, E_00012B = 24'hFFF12B;
`else
  localparam logic [23:0] E_001234 = 24'h001234, E_000000 = 24'h000000,
                          E_000005 = 24'h000005, E_0A0B00 = 24'h0A0B00,
                          E_000987 = 24'h000987, E_000333 = 24'h000333,
                          E_000042 = 24'h000042, E_00012B = 24'h00012B;
`endif

  typedef struct {
    logic        is_msg;
    logic [23:0] d;
    logic [23:0] e;
  } vec_t;
  vec_t tbl [6];

  oled_refresh_scheduler #(.DIGITS_NUM(DN), .MIN_PERIOD_CYCLES(MP), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .meas_digits_in(meas_digits_in), .meas_valid_in(meas_valid_in),
    .msg_digits_in(msg_digits_in), .msg_valid_in(msg_valid_in),
    .msg_hold_in(msg_hold_in), .digits_out(digits_out),
    .refresh_stb_out(refresh_stb_out), .streamer_ready_in(streamer_ready_in),
    .busy_out(busy_out), .timeout_out(timeout_out), .overrun_cnt_out(overrun_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  // Streamer model: independent of scheduler reset.
  always @(posedge clk_in) begin
    if (refresh_stb_out && !stuck) begin
      streamer_ready_in <= 1'b0;
      scnt              <= FRAME;
    end else if (scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) streamer_ready_in <= 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk_in); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic pulse(input logic m, input logic [23:0] d);
    if (m) begin msg_digits_in = d; msg_valid_in = 1'b1; end
    else   begin meas_digits_in = d; meas_valid_in = 1'b1; end
    tick;
    msg_valid_in  = 1'b0;
    meas_valid_in = 1'b0;
  endtask

  task automatic wait_stb(input int lim, output int n);
    n = 0;
    while (!refresh_stb_out && n < lim) begin tick; n++; end
    if (!refresh_stb_out) n = -1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_out && n < 100) begin tick; n++; end
    chk(nm, {31'd0, busy_out}, 32'd0);
  endtask

  task automatic count_stb(input int cyc, output int c);
    c = 0;
    for (int i = 0; i < cyc; i++) begin tick; if (refresh_stb_out) c++; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c;
    tbl[0] = '{1'b0, 24'h000000, E_000000};
    tbl[1] = '{1'b0, 24'h000005, E_000005};
    tbl[2] = '{1'b0, 24'h100000, 24'h100000};
    tbl[3] = '{1'b1, 24'h000012, 24'h000012};
    tbl[4] = '{1'b0, 24'h0A0B00, E_0A0B00};
    tbl[5] = '{1'b1, 24'h000000, 24'h000000};

    stuck = 1'b0;
    reset_n_in = 1'b0;
    meas_digits_in = '0; msg_digits_in = '0;
    meas_valid_in = 1'b0; msg_valid_in = 1'b0; msg_hold_in = 1'b0;
    repeat (3) tick;
    chk("rst_digits", {8'd0, digits_out}, 32'd0);
    chk("rst_flags", {29'd0, refresh_stb_out, busy_out, timeout_out}, 32'd0);
    chk("rst_ovr", {24'd0, overrun_cnt_out}, 32'd0);
    reset_n_in = 1'b1;
    tick;

    // First frame is not rate-limited: strobe two cycles after the valid.
    pulse(1'b0, 24'h001234);
    wait_stb(10, n);
    chk("t1_lat", n, 1);
    chk("t1_digits", {8'd0, digits_out}, {8'd0, E_001234});
    chk("t1_busy", {31'd0, busy_out}, 1);
    tick;
    chk("t1_stb_1cyc", {31'd0, refresh_stb_out}, 0);
    wait_idle("t1_idle");
    repeat (20) tick;

    for (int i = 0; i < 6; i++) begin
      pulse(tbl[i].is_msg, tbl[i].d);
      wait_stb(10, n);
      chk($sformatf("v%0d_lat", i), n, 1);
      chk($sformatf("v%0d_digits", i), {8'd0, digits_out}, {8'd0, tbl[i].e});
      tick;
      chk($sformatf("v%0d_stb_1cyc", i), {31'd0, refresh_stb_out}, 0);
      chk($sformatf("v%0d_busy", i), {31'd0, busy_out}, 1);
      wait_idle($sformatf("v%0d_idle", i));
      repeat (20) tick;
    end

    // Simultaneous requests: msg first, meas exactly MIN_PERIOD later.
    meas_digits_in = 24'h000987; meas_valid_in = 1'b1;
    msg_digits_in  = 24'h0000AB; msg_valid_in  = 1'b1;
    tick;
    meas_valid_in = 1'b0; msg_valid_in = 1'b0;
    wait_stb(10, n);
    chk("t2_msg_lat", n, 1);
    chk("t2_msg_digits", {8'd0, digits_out}, 32'h0000AB);
    tick;
    wait_stb(40, n);
    chk("t2_spacing", n + 1, MP);
    chk("t2_meas_digits", {8'd0, digits_out}, {8'd0, E_000987});
    wait_idle("t2_idle");
    repeat (20) tick;

    // Hold: meas stays pending, overwrites counted.
    msg_hold_in = 1'b1;
    pulse(1'b0, 24'h000111); repeat (3) tick;
    pulse(1'b0, 24'h000222); repeat (3) tick;
    pulse(1'b0, 24'h000333);
    count_stb(30, c);
    chk("t3_no_stb", c, 0);
    chk("t3_ovr", {24'd0, overrun_cnt_out}, 2);
    msg_hold_in = 1'b0;
    wait_stb(10, n);
    chk("t3_lat", n, 1);
    chk("t3_digits", {8'd0, digits_out}, {8'd0, E_000333});
    wait_idle("t3_idle");
    repeat (20) tick;

    // Watchdog: streamer never drops ready.
    stuck = 1'b1;
    pulse(1'b1, 24'h00BEEF);
    wait_stb(10, n);
    chk("t4_lat", n, 1);
    n = 0;
    while (!timeout_out && n < 100) begin tick; n++; end
    chk("t4_tmo_window", {31'd0, (n >= TO - 1) && (n <= TO + 2)}, 1);
    chk("t4_busy", {31'd0, busy_out}, 0);
    chk("t4_digits_kept", {8'd0, digits_out}, 32'h00BEEF);
    stuck = 1'b0;
    pulse(1'b0, 24'h000042);
    wait_stb(10, n);
    chk("t4_next_lat", n, 1);
    chk("t4_next_digits", {8'd0, digits_out}, {8'd0, E_000042});
    chk("t4_sticky", {31'd0, timeout_out}, 1);
    wait_idle("t4_idle");
    repeat (20) tick;

    // Async reset in WAIT_DONE.
    pulse(1'b0, 24'h000777);
    wait_stb(10, n);
    chk("t5_lat", n, 1);
    repeat (3) tick;
    chk("t5_busy_pre", {31'd0, busy_out}, 1);
    #2 reset_n_in = 1'b0;
    #1;
    chk("t5_rst_digits", {8'd0, digits_out}, 32'd0);
    chk("t5_rst_flags", {29'd0, refresh_stb_out, busy_out, timeout_out}, 32'd0);
    chk("t5_rst_ovr", {24'd0, overrun_cnt_out}, 32'd0);
    tick; tick;
    reset_n_in = 1'b1;
    count_stb(40, c);
    chk("t5_no_stb", c, 0);
    pulse(1'b1, 24'h000001);
    wait_stb(10, n);
    chk("t5_after_lat", n, 1);
    chk("t5_after_digits", {8'd0, digits_out}, 32'h000001);
    wait_idle("t5_idle");
    repeat (20) tick;

    // Overrun saturation.
    msg_hold_in = 1'b1;
    c = 0;
    for (int i = 0; i < 300; i++) begin
      meas_digits_in = 24'(i); meas_valid_in = 1'b1;
      tick;
      if (refresh_stb_out) c++;
    end
    meas_valid_in = 1'b0;
    chk("t6_no_stb", c, 0);
    chk("t6_ovr_sat", {24'd0, overrun_cnt_out}, 255);
    msg_hold_in = 1'b0;
    wait_stb(10, n);
    chk("t6_lat", n, 1);
    chk("t6_digits", {8'd0, digits_out}, {8'd0, E_00012B});
    wait_idle("t6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
